// File: rtl/mc_cpu_core.sv
// rtl/mc_cpu_core.sv - multi-cycle MIPS-subset core with request/ready instruction and data ports
module mc_cpu_core #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_ready,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ready,
    output logic [ADDR_W-1:0] pc,
    output logic [31:0]       inst,
    output logic [2:0]        state,
    output logic              retire,
    output logic              halted
);

    localparam logic [2:0] S_IF   = 3'd0;
    localparam logic [2:0] S_ID   = 3'd1;
    localparam logic [2:0] S_EX   = 3'd2;
    localparam logic [2:0] S_MEM  = 3'd3;
    localparam logic [2:0] S_WB   = 3'd4;
    localparam logic [2:0] S_HALT = 3'd5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;

    localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] J_REGION = ADDR_W'(28'hFFF_FFFF);

    logic [2:0]        state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [31:0]       inst_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] alu_q;
    logic [DATA_W-1:0] mdr_q;
    logic [DATA_W-1:0] regs [0:31];

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;

    assign opcode = inst_q[31:26];
    assign rs     = inst_q[25:21];
    assign rt     = inst_q[20:16];
    assign rd     = inst_q[15:11];
    assign imm    = inst_q[15:0];
    assign funct  = inst_q[5:0];

    logic is_rtype, is_addi, is_lw, is_sw, is_beq, is_j;
    logic funct_ok, supported;

    assign is_rtype = (opcode == OP_RTYPE);
    assign is_addi  = (opcode == OP_ADDI);
    assign is_lw    = (opcode == OP_LW);
    assign is_sw    = (opcode == OP_SW);
    assign is_beq   = (opcode == OP_BEQ);
    assign is_j     = (opcode == OP_J);

    always_comb begin
        funct_ok = 1'b0;
        case (funct)
            F_ADD, F_SUB, F_AND, F_OR, F_SLT: funct_ok = 1'b1;
            default:                          funct_ok = 1'b0;
        endcase
    end

    assign supported = (is_rtype && funct_ok) || is_addi || is_lw || is_sw || is_beq || is_j;

    logic [DATA_W-1:0] imm_sext;
    logic [ADDR_W-1:0] br_off;
    logic [ADDR_W-1:0] jump_target;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;

    assign imm_sext    = {{(DATA_W-16){imm[15]}}, imm};
    assign br_off      = {{(ADDR_W-18){imm[15]}}, imm, 2'b00};
    // j keeps the upper PC bits of the already-incremented PC
    assign jump_target = (pc_q & ~J_REGION) | ADDR_W'({inst_q[25:0], 2'b00});
    assign rs_val      = (rs == 5'd0) ? '0 : regs[rs];
    assign rt_val      = (rt == 5'd0) ? '0 : regs[rt];

    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_res;
    logic              slt_bit;

    always_comb begin
        alu_b   = is_rtype ? b_q : imm_sext;
        slt_bit = ($signed(a_q) < $signed(alu_b));
        alu_res = a_q + alu_b;
        if (is_rtype) begin
            case (funct)
                F_SUB:   alu_res = a_q - alu_b;
                F_AND:   alu_res = a_q & alu_b;
                F_OR:    alu_res = a_q | alu_b;
                F_SLT:   alu_res = {{(DATA_W-1){1'b0}}, slt_bit};
                default: alu_res = a_q + alu_b;
            endcase
        end else if (is_beq) begin
            alu_res = a_q - b_q;
        end
    end

    logic [4:0]        wb_dest;
    logic [DATA_W-1:0] wb_data;

    assign wb_dest = is_rtype ? rd : rt;
    assign wb_data = is_lw ? mdr_q : alu_q;

    assign imem_req   = (state_q == S_IF) && !rst;
    assign imem_addr  = pc_q;
    assign dmem_req   = (state_q == S_MEM) && !rst;
    assign dmem_we    = dmem_req && is_sw;
    assign dmem_addr  = ADDR_W'(alu_q);
    assign dmem_wdata = b_q;
    assign pc         = pc_q;
    assign inst       = inst_q;
    assign state      = state_q;
    assign halted     = (state_q == S_HALT);

    always_comb begin
        retire = 1'b0;
        if (!rst) begin
            case (state_q)
                S_ID:    retire = is_j;
                S_EX:    retire = is_beq;
                S_MEM:   retire = dmem_ready && is_sw;
                S_WB:    retire = 1'b1;
                default: retire = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IF;
            pc_q    <= RESET_PC;
            inst_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            alu_q   <= '0;
            mdr_q   <= '0;
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state_q)
                S_IF: begin
                    if (imem_ready) begin
                        inst_q  <= imem_rdata;
                        pc_q    <= pc_q + PC_STEP;
                        state_q <= S_ID;
                    end
                end
                S_ID: begin
                    a_q <= rs_val;
                    b_q <= rt_val;
                    if (!supported) begin
                        state_q <= S_HALT;
                    end else if (is_j) begin
                        pc_q    <= jump_target;
                        state_q <= S_IF;
                    end else begin
                        state_q <= S_EX;
                    end
                end
                S_EX: begin
                    alu_q <= alu_res;
                    if (is_beq) begin
                        if (a_q == b_q) begin
                            pc_q <= pc_q + br_off;
                        end
                        state_q <= S_IF;
                    end else if (is_lw || is_sw) begin
                        state_q <= S_MEM;
                    end else begin
                        state_q <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        if (is_sw) begin
                            state_q <= S_IF;
                        end else begin
                            mdr_q   <= dmem_rdata;
                            state_q <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    if (wb_dest != 5'd0) begin
                        regs[wb_dest] <= wb_data;
                    end
                    state_q <= S_IF;
                end
                S_HALT:  state_q <= S_HALT;
                default: state_q <= S_HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_cpu_core.sv
// tb/tb_mc_cpu_core.sv - directed vector bench for mc_cpu_core with wait-state memory models
module tb_mc_cpu_core;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [2:0]  state;
    logic        retire;
    logic        halted;

    mc_cpu_core dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ready (dmem_ready),
        .pc         (pc),
        .inst       (inst),
        .state      (state),
        .retire     (retire),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    logic [31:0] imem [0:63];
    logic [31:0] dmem [0:63];
    int imem_wait = 0;
    int dmem_wait = 0;
    int icnt = 0;
    int dcnt = 0;

    // memory responders settle 1 time unit after every clock edge
    initial begin
        imem_ready = 1'b0;
        imem_rdata = '0;
        dmem_ready = 1'b0;
        dmem_rdata = '0;
        forever begin
            @(posedge clk or negedge clk);
            #1;
            imem_rdata = imem[imem_addr[7:2]];
            imem_ready = imem_req && (icnt >= imem_wait);
            dmem_rdata = dmem[dmem_addr[7:2]];
            dmem_ready = dmem_req && (dcnt >= dmem_wait);
        end
    end

    always @(posedge clk) begin
        icnt <= (imem_req && !imem_ready) ? icnt + 1 : 0;
        dcnt <= (dmem_req && !dmem_ready) ? dcnt + 1 : 0;
        if (rst) begin
            for (int i = 0; i < 64; i++) dmem[i] <= '0;
        end else if (dmem_req && dmem_ready && dmem_we) begin
            dmem[dmem_addr[7:2]] <= dmem_wdata;
        end
    end

    logic        dpend = 1'b0;
    logic [31:0] d_addr_s;
    logic [31:0] d_wdata_s;
    logic        d_we_s;

    always @(negedge clk) begin
        #3;
        check("imem_req only in IF", 32'(imem_req), 32'((state == 3'd0) && !rst));
        check("dmem_req only in MEM", 32'(dmem_req), 32'((state == 3'd3) && !rst));
        if (dpend && dmem_req) begin
            check("dmem_addr stable", dmem_addr, d_addr_s);
            check("dmem_we stable", 32'(dmem_we), 32'(d_we_s));
            check("dmem_wdata stable", dmem_wdata, d_wdata_s);
        end
        dpend     = dmem_req && !dmem_ready;
        d_addr_s  = dmem_addr;
        d_we_s    = dmem_we;
        d_wdata_s = dmem_wdata;
    end

    initial begin
        #100000;
        $display("FAIL global timeout");
        $fatal(1, "bench timeout");
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset state", 32'(state), 32'd0);
        check("reset pc", pc, 32'h0);
        check("reset inst", inst, 32'h0);
        check("reset halted", 32'(halted), 32'd0);
        check("reset imem_req", 32'(imem_req), 32'd0);
        check("reset dmem_req", 32'(dmem_req), 32'd0);
        check("reset retire", 32'(retire), 32'd0);
        check("reset reg1", dut.regs[1], 32'h0);
        rst = 1'b0;
    endtask

    // entered on the negedge of an instruction's first IF cycle; leaves on the next one
    task automatic run_instr(output int cyc, output logic [2:0] st);
        cyc = 1;
        while (!retire && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        if (!retire) begin
            tests++;
            fails++;
            $display("FAIL retire timeout: got none expected pulse within 40 cycles");
        end
        st = state;
        @(negedge clk);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] word;
        int          iw;
        int          dw;
        int          cyc;
        logic [31:0] pc;
        bit          is_mem;
        int          idx;
        logic [31:0] val;
    } vec_t;

    vec_t vecs [15];

    initial begin
        int          cyc;
        logic [2:0]  st;
        logic        saw;
        logic [31:0] act;

        rst = 1'b1;
        vecs[0]  = '{32'h00, 32'h20010005, 0, 0, 4, 32'h04, 1'b0, 1,  32'h00000005};
        vecs[1]  = '{32'h04, 32'h2002FFFD, 0, 0, 4, 32'h08, 1'b0, 2,  32'hFFFFFFFD};
        vecs[2]  = '{32'h08, 32'h00221820, 0, 0, 4, 32'h0C, 1'b0, 3,  32'h00000002};
        vecs[3]  = '{32'h0C, 32'h0041202A, 0, 0, 4, 32'h10, 1'b0, 4,  32'h00000001};
        vecs[4]  = '{32'h10, 32'h00413022, 2, 0, 6, 32'h14, 1'b0, 6,  32'hFFFFFFF8};
        vecs[5]  = '{32'h14, 32'h00C24024, 0, 0, 4, 32'h18, 1'b0, 8,  32'hFFFFFFF8};
        vecs[6]  = '{32'h18, 32'h00233825, 0, 0, 4, 32'h1C, 1'b0, 7,  32'h00000007};
        vecs[7]  = '{32'h1C, 32'h0022202A, 0, 0, 4, 32'h20, 1'b0, 4,  32'h00000000};
        vecs[8]  = '{32'h20, 32'h20000007, 1, 0, 5, 32'h24, 1'b0, 0,  32'h00000000};
        vecs[9]  = '{32'h24, 32'hAC010008, 0, 1, 5, 32'h28, 1'b1, 2,  32'h00000005};
        vecs[10] = '{32'h28, 32'h8C050008, 0, 3, 8, 32'h2C, 1'b0, 5,  32'h00000005};
        vecs[11] = '{32'h2C, 32'h10220005, 0, 0, 3, 32'h30, 1'b0, 1,  32'h00000005};
        vecs[12] = '{32'h30, 32'h10210001, 1, 0, 4, 32'h38, 1'b0, 1,  32'h00000005};
        vecs[13] = '{32'h38, 32'h08000010, 0, 0, 2, 32'h40, 1'b0, 1,  32'h00000005};
        vecs[14] = '{32'h40, 32'h204A0004, 0, 0, 4, 32'h44, 1'b0, 10, 32'h00000001};

        for (int i = 0; i < 64; i++) imem[i] = 32'hFC000000;
        for (int i = 0; i < 15; i++) imem[vecs[i].addr[7:2]] = vecs[i].word;

        do_reset();
        for (int i = 0; i < 15; i++) begin
            imem_wait = vecs[i].iw;
            dmem_wait = vecs[i].dw;
            run_instr(cyc, st);
            check($sformatf("v%0d cycles", i), 32'(cyc), 32'(vecs[i].cyc));
            check($sformatf("v%0d pc", i), pc, vecs[i].pc);
            act = vecs[i].is_mem ? dmem[vecs[i].idx] : dut.regs[vecs[i].idx];
            check($sformatf("v%0d result", i), act, vecs[i].val);
        end

        imem_wait = 0;
        dmem_wait = 0;
        repeat (2) @(negedge clk);
        check("halt state", 32'(state), 32'd5);
        check("halt flag", 32'(halted), 32'd1);
        saw = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (imem_req || dmem_req || retire) saw = 1'b1;
        end
        check("halt quiet", 32'(saw), 32'd0);
        check("halt pc frozen", pc, 32'h48);
        check("halt sticky", 32'(state), 32'd5);

        for (int i = 0; i < 64; i++) imem[i] = 32'hFC000000;
        imem[0] = 32'h08000004;
        imem[4] = 32'h1000FFFF;
        do_reset();
        #2;
        check("imem_req after reset", 32'(imem_req), 32'd1);
        run_instr(cyc, st);
        check("j cycles", 32'(cyc), 32'd2);
        check("j retire in ID", 32'(st), 32'd1);
        check("j pc", pc, 32'h10);
        run_instr(cyc, st);
        check("beq loop cycles", 32'(cyc), 32'd3);
        check("beq loop pc", pc, 32'h10);
        imem_wait = 1;
        run_instr(cyc, st);
        check("beq loop wait cycles", 32'(cyc), 32'd4);
        check("beq loop wait pc", pc, 32'h10);

        imem_wait = 1000;
        repeat (3) @(negedge clk);
        check("IF wait state", 32'(state), 32'd0);
        check("IF wait req", 32'(imem_req), 32'd1);
        check("IF wait pc", pc, 32'h10);
        rst = 1'b1;
        @(negedge clk);
        check("rst in IF wait state", 32'(state), 32'd0);
        check("rst in IF wait pc", pc, 32'h0);
        check("rst in IF wait req", 32'(imem_req), 32'd0);
        check("rst in IF wait retire", 32'(retire), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
